// File: rtl/des_key_schedule.sv
// -----------------------------------------------------------------------------
// des_key_schedule
//   Sequential DES key schedule. One 64-bit key is accepted while idle. The
//   sixteen 48-bit round keys then leave on a valid/ready stream, one per
//   transfer. Encrypt mode emits K1..K16 and decrypt mode emits K16..K1.
//   Only the current C/D halves are stored. Decrypt rotates them right to walk
//   the schedule backwards, so the other round keys are never kept.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   key_valid_i         key_i / decrypt_i valid
//   key_ready_o         high while idle (a key can be accepted)
//   key_i [63:0]        DES key, FIPS bit 1 = key_i[63], parity bits ignored
//   decrypt_i           1 = K16..K1, 0 = K1..K16, sampled at acceptance
//   round_key_o [47:0]  round key, FIPS bit 1 = round_key_o[47]
//   round_key_valid_o   round_key_o valid
//   round_key_ready_i   downstream accepts round_key_o
//   round_idx_o [3:0]   transfer index 0..15 (stream order, not key number)
//   round_last_o        high with the 16th round key
// -----------------------------------------------------------------------------
module des_key_schedule (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_valid_i,
    output logic        key_ready_o,
    input  logic [63:0] key_i,
    input  logic        decrypt_i,
    output logic [47:0] round_key_o,
    output logic        round_key_valid_o,
    input  logic        round_key_ready_i,
    output logic [3:0]  round_idx_o,
    output logic        round_last_o
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_GEN  = 1'b1
    } state_e;

    // Permuted choice 1. Entries are FIPS bit numbers (1 = MSB of key_i).
    localparam int PC1_TAB [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    // Permuted choice 2 over {C,D}. Bit 1 is the MSB of C.
    localparam int PC2_TAB [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    // Bit k set means that rotation step s(k+1) is 2; otherwise the step is 1.
    localparam logic [15:0] SHIFT2 = 16'b0111_1110_1111_1100;

    function automatic logic [27:0] rotl28(input logic [27:0] x, input logic two);
        return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

    function automatic logic [27:0] rotr28(input logic [27:0] x, input logic two);
        return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

    state_e      state_q, state_d;
    logic [27:0] c_q, c_d;
    logic [27:0] d_q, d_d;
    logic        dec_q, dec_d;
    logic [3:0]  idx_q, idx_d;
    logic        last_q, last_d;
    logic [47:0] round_key_q, round_key_d;
    logic        key_load;

    logic [55:0] pc1_key;
    logic [47:0] pc2_key;
    logic [3:0]  enc_sel;
    logic [3:0]  dec_sel;

    // Parity bits (FIPS 8,16,..,64) do not take part in the schedule.
    logic        key_parity_unused;
    assign key_parity_unused = ^{key_i[56], key_i[48], key_i[40], key_i[32],
                                 key_i[24], key_i[16], key_i[8],  key_i[0]};

    genvar gi;
    generate
        for (gi = 0; gi < 56; gi++) begin : g_pc1
            assign pc1_key[55-gi] = key_i[64-PC1_TAB[gi]];
        end
        // PC-2 is applied to the next-state C/D. The registered round key is
        // then always the key that matches the C/D being loaded.
        for (gi = 0; gi < 48; gi++) begin : g_pc2
            assign pc2_key[47-gi] = (PC2_TAB[gi] <= 28) ? c_d[28-PC2_TAB[gi]]
                                                        : d_d[56-PC2_TAB[gi]];
        end
    endgenerate

    // After transfer t the encrypt walk needs s(t+2) and the decrypt walk
    // undoes s(16-t).
    assign enc_sel = idx_q + 4'd1;
    assign dec_sel = 4'd15 - idx_q;

    always_comb begin
        state_d  = state_q;
        c_d      = c_q;
        d_d      = d_q;
        dec_d    = dec_q;
        idx_d    = idx_q;
        last_d   = last_q;
        key_load = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (key_valid_i) begin
                    state_d  = S_GEN;
                    dec_d    = decrypt_i;
                    idx_d    = 4'd0;
                    last_d   = 1'b0;
                    key_load = 1'b1;
                    if (decrypt_i) begin
                        // The total rotation is 28, so C16/D16 equal C0/D0.
                        c_d = pc1_key[55:28];
                        d_d = pc1_key[27:0];
                    end else begin
                        c_d = rotl28(pc1_key[55:28], 1'b0);
                        d_d = rotl28(pc1_key[27:0], 1'b0);
                    end
                end
            end
            S_GEN: begin
                if (round_key_ready_i) begin
                    if (last_q) begin
                        state_d = S_IDLE;
                        idx_d   = 4'd0;
                        last_d  = 1'b0;
                    end else begin
                        idx_d    = idx_q + 4'd1;
                        last_d   = (idx_q == 4'd14);
                        key_load = 1'b1;
                        if (dec_q) begin
                            c_d = rotr28(c_q, SHIFT2[dec_sel]);
                            d_d = rotr28(d_q, SHIFT2[dec_sel]);
                        end else begin
                            c_d = rotl28(c_q, SHIFT2[enc_sel]);
                            d_d = rotl28(d_q, SHIFT2[enc_sel]);
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign round_key_d = key_load ? pc2_key : round_key_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            c_q         <= '0;
            d_q         <= '0;
            dec_q       <= 1'b0;
            idx_q       <= 4'd0;
            last_q      <= 1'b0;
            round_key_q <= '0;
        end else begin
            state_q     <= state_d;
            c_q         <= c_d;
            d_q         <= d_d;
            dec_q       <= dec_d;
            idx_q       <= idx_d;
            last_q      <= last_d;
            round_key_q <= round_key_d;
        end
    end

    assign key_ready_o       = (state_q == S_IDLE);
    assign round_key_valid_o = (state_q == S_GEN);
    assign round_key_o       = round_key_q;
    assign round_idx_o       = idx_q;
    assign round_last_o      = last_q;

endmodule

// File: tb/tb_des_key_schedule.sv
module tb_des_key_schedule;

    logic        clk = 1'b0;
    logic        rst;
    logic        key_valid_i;
    logic        key_ready_o;
    logic [63:0] key_i;
    logic        decrypt_i;
    logic [47:0] round_key_o;
    logic        round_key_valid_o;
    logic        round_key_ready_i;
    logic [3:0]  round_idx_o;
    logic        round_last_o;

    always #5 clk = ~clk;

    des_key_schedule dut (
        .clk               (clk),
        .rst               (rst),
        .key_valid_i       (key_valid_i),
        .key_ready_o       (key_ready_o),
        .key_i             (key_i),
        .decrypt_i         (decrypt_i),
        .round_key_o       (round_key_o),
        .round_key_valid_o (round_key_valid_o),
        .round_key_ready_i (round_key_ready_i),
        .round_idx_o       (round_idx_o),
        .round_last_o      (round_last_o)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // FIPS 46-3 tables
    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    // Reference: Kn from the cumulative left rotation of C0/D0 by s1+..+sn.
    function automatic logic [47:0] ref_key(input logic [63:0] key, input int n);
        logic [27:0] c;
        logic [27:0] d;
        logic [63:0] t64;
        logic [55:0] cd;
        logic [55:0] t56;
        logic [47:0] k;
        int          tot;
        c = '0;
        d = '0;
        k = '0;
        for (int i = 0; i < 28; i++) begin
            t64 = key >> (64 - PC1_T[i]);
            c   = {c[26:0], t64[0]};
            t64 = key >> (64 - PC1_T[28 + i]);
            d   = {d[26:0], t64[0]};
        end
        tot = 0;
        for (int i = 0; i < n; i++) tot += SHIFTS[i];
        tot = tot % 28;
        c = (c << tot) | (c >> (28 - tot));
        d = (d << tot) | (d >> (28 - tot));
        cd = {c, d};
        for (int i = 0; i < 48; i++) begin
            t56 = cd >> (56 - PC2_T[i]);
            k   = {k[46:0], t56[0]};
        end
        return k;
    endfunction

    logic [47:0] cap_key  [16];
    logic [3:0]  cap_idx  [16];
    logic        cap_last [16];
    int          cap_n;
    int          cap_cycles;
    logic [47:0] saved_key [16];

    // Present one key and collect its 16 round keys.
    // mode 0: ready always high; mode 1: ready random 50%.
    // stall_idx >= 0 forces three cycles of ready low at that index.
    // noise toggles the key inputs randomly while the schedule runs.
    task automatic run_key(input logic [63:0] key, input logic dec, input int mode,
                           input int stall_idx, input logic noise);
        int          cyc;
        int          stall_left;
        logic        rdy;
        logic        pstall;
        logic        stall_done;
        logic [47:0] pk;
        logic [3:0]  pi;
        logic        pl;
        cap_n = 0;
        cyc   = 0;
        while (key_ready_o !== 1'b1 && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        n_checks++;
        if (key_ready_o !== 1'b1) $display("FAIL idle_before_key got %b exp 1", key_ready_o);
        else n_pass++;
        key_valid_i = 1'b1;
        key_i       = key;
        decrypt_i   = dec;
        @(posedge clk); #1;
        key_valid_i = noise;
        cyc = 0; stall_left = 0; pstall = 1'b0; stall_done = 1'b0;
        pk = '0; pi = '0; pl = 1'b0;
        while (cap_n < 16 && cyc < 400) begin
            if (pstall) begin
                n_checks++;
                if (round_key_valid_o !== 1'b1 || round_key_o !== pk || round_idx_o !== pi || round_last_o !== pl)
                    $display("FAIL stall_hold got v=%b k=%h i=%0d l=%b exp v=1 k=%h i=%0d l=%b",
                             round_key_valid_o, round_key_o, round_idx_o, round_last_o, pk, pi, pl);
                else n_pass++;
            end
            n_checks++;
            if (key_ready_o !== 1'b0) $display("FAIL busy_key_ready got %b exp 0", key_ready_o);
            else n_pass++;
            if (stall_idx >= 0 && !stall_done && round_key_valid_o === 1'b1 && int'(round_idx_o) == stall_idx) begin
                stall_left = 3;
                stall_done = 1'b1;
            end
            if (stall_left > 0) begin
                rdy = 1'b0;
                stall_left--;
            end else if (mode == 1) rdy = 1'($urandom_range(0, 1));
            else rdy = 1'b1;
            round_key_ready_i = rdy;
            if (round_key_valid_o === 1'b1 && rdy) begin
                cap_key[cap_n]  = round_key_o;
                cap_idx[cap_n]  = round_idx_o;
                cap_last[cap_n] = round_last_o;
                cap_n++;
            end
            pstall = (round_key_valid_o === 1'b1) && !rdy;
            pk = round_key_o; pi = round_idx_o; pl = round_last_o;
            if (noise) begin
                key_i     = {$urandom, $urandom};
                decrypt_i = 1'($urandom_range(0, 1));
            end
            @(posedge clk); #1;
            cyc++;
        end
        cap_cycles = cyc;
        n_checks++;
        if (cap_n != 16) $display("FAIL transfer_count got %0d exp 16", cap_n);
        else n_pass++;
        // The cycle after the last transfer the block is idle again.
        n_checks++;
        if (round_key_valid_o !== 1'b0 || key_ready_o !== 1'b1 || round_idx_o !== 4'd0 || round_last_o !== 1'b0)
            $display("FAIL post_last got v=%b kr=%b i=%0d l=%b exp v=0 kr=1 i=0 l=0",
                     round_key_valid_o, key_ready_o, round_idx_o, round_last_o);
        else n_pass++;
        key_valid_i       = 1'b0;
        round_key_ready_i = 1'($urandom_range(0, 1));
        $display("run key=%h dec=%b mode=%0d transfers=%0d cycles=%0d", key, dec, mode, cap_n, cap_cycles);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        key_valid_i = 1'b0; key_i = '0; decrypt_i = 1'b0; round_key_ready_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (key_ready_o !== 1'b1) $display("FAIL reset_key_ready got %b exp 1", key_ready_o); else n_pass++;
        n_checks++;
        if (round_key_valid_o !== 1'b0) $display("FAIL reset_valid got %b exp 0", round_key_valid_o); else n_pass++;
        n_checks++;
        if (round_key_o !== 48'h0) $display("FAIL reset_key got %h exp 0", round_key_o); else n_pass++;
        n_checks++;
        if (round_idx_o !== 4'd0) $display("FAIL reset_idx got %0d exp 0", round_idx_o); else n_pass++;
        n_checks++;
        if (round_last_o !== 1'b0) $display("FAIL reset_last got %b exp 0", round_last_o); else n_pass++;
        rst = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (key_ready_o !== 1'b1 || round_key_valid_o !== 1'b0)
            $display("FAIL idle_after_release got kr=%b v=%b exp kr=1 v=0", key_ready_o, round_key_valid_o);
        else n_pass++;
    endtask

    task automatic test_encrypt_vector();
        run_key(64'h133457799BBCDFF1, 1'b0, 0, -1, 1'b0);
        n_checks++;
        if (cap_cycles != 16) $display("FAIL enc_no_bubble got %0d cycles exp 16", cap_cycles); else n_pass++;
        n_checks++;
        if (cap_key[0] !== 48'h1B02EFFC7072) $display("FAIL enc_k1 got %h exp 1b02effc7072", cap_key[0]); else n_pass++;
        n_checks++;
        if (cap_key[1] !== 48'h79AED9DBC9E5) $display("FAIL enc_k2 got %h exp 79aed9dbc9e5", cap_key[1]); else n_pass++;
        n_checks++;
        if (cap_key[15] !== 48'hCB3D8B0E17F5 || cap_last[15] !== 1'b1)
            $display("FAIL enc_k16 got %h last=%b exp cb3d8b0e17f5 last=1", cap_key[15], cap_last[15]);
        else n_pass++;
        for (int t = 0; t < 16; t++) begin
            saved_key[t] = cap_key[t];
            n_checks++;
            if (cap_key[t] !== ref_key(64'h133457799BBCDFF1, t + 1) || cap_idx[t] !== 4'(t) || cap_last[t] !== (t == 15))
                $display("FAIL enc_seq t=%0d got k=%h i=%0d l=%b exp k=%h i=%0d l=%b", t, cap_key[t], cap_idx[t],
                         cap_last[t], ref_key(64'h133457799BBCDFF1, t + 1), t, (t == 15));
            else n_pass++;
        end
    endtask

    task automatic test_decrypt_vector();
        run_key(64'h133457799BBCDFF1, 1'b1, 0, -1, 1'b0);
        n_checks++;
        if (cap_cycles != 16) $display("FAIL dec_no_bubble got %0d cycles exp 16", cap_cycles); else n_pass++;
        n_checks++;
        if (cap_key[0] !== 48'hCB3D8B0E17F5) $display("FAIL dec_first got %h exp cb3d8b0e17f5", cap_key[0]); else n_pass++;
        n_checks++;
        if (cap_key[14] !== 48'h79AED9DBC9E5) $display("FAIL dec_idx14 got %h exp 79aed9dbc9e5", cap_key[14]); else n_pass++;
        n_checks++;
        if (cap_key[15] !== 48'h1B02EFFC7072) $display("FAIL dec_last got %h exp 1b02effc7072", cap_key[15]); else n_pass++;
        for (int t = 0; t < 16; t++) begin
            n_checks++;
            if (cap_key[t] !== saved_key[15 - t] || cap_idx[t] !== 4'(t) || cap_last[t] !== (t == 15))
                $display("FAIL dec_reverse t=%0d got k=%h i=%0d l=%b exp k=%h i=%0d l=%b", t, cap_key[t],
                         cap_idx[t], cap_last[t], saved_key[15 - t], t, (t == 15));
            else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] key;
        key = {$urandom, $urandom};
        run_key(key, 1'b0, 1, 8, 1'b0);
        for (int t = 0; t < 16; t++) begin
            n_checks++;
            if (cap_key[t] !== ref_key(key, t + 1) || cap_idx[t] !== 4'(t))
                $display("FAIL bp_seq t=%0d got k=%h i=%0d exp k=%h i=%0d", t, cap_key[t], cap_idx[t], ref_key(key, t + 1), t);
            else n_pass++;
        end
        run_key(64'h133457799BBCDFF1, 1'b0, 1, 8, 1'b0);
        for (int t = 0; t < 16; t++) begin
            n_checks++;
            if (cap_key[t] !== saved_key[t])
                $display("FAIL bp_vs_unstalled t=%0d got %h exp %h", t, cap_key[t], saved_key[t]);
            else n_pass++;
        end
    endtask

    task automatic test_parity();
        logic [63:0] key_a;
        logic [63:0] key_b;
        logic        dec;
        for (int r = 0; r < 2; r++) begin
            key_a = (r == 0) ? 64'h133457799BBCDFF1 : {$urandom, $urandom};
            key_b = key_a ^ (({$urandom, $urandom} & 64'h0101010101010101) | 64'h0100000000000001);
            dec   = 1'(r);
            run_key(key_a, dec, 0, -1, 1'b0);
            for (int t = 0; t < 16; t++) saved_key[t] = cap_key[t];
            run_key(key_b, dec, 1, -1, 1'b0);
            for (int t = 0; t < 16; t++) begin
                n_checks++;
                if (cap_key[t] !== saved_key[t] || cap_key[t] !== ref_key(key_a, dec ? 16 - t : t + 1))
                    $display("FAIL parity t=%0d got %h exp %h", t, cap_key[t], ref_key(key_a, dec ? 16 - t : t + 1));
                else n_pass++;
            end
        end
    endtask

    task automatic test_random();
        logic [63:0] key;
        logic        dec;
        for (int r = 0; r < 6; r++) begin
            key = {$urandom, $urandom};
            dec = 1'($urandom_range(0, 1));
            run_key(key, dec, r % 2, -1, 1'b1);
            for (int t = 0; t < 16; t++) begin
                n_checks++;
                if (cap_key[t] !== ref_key(key, dec ? 16 - t : t + 1) || cap_idx[t] !== 4'(t) || cap_last[t] !== (t == 15))
                    $display("FAIL random_seq r=%0d t=%0d got k=%h i=%0d exp k=%h i=%0d", r, t, cap_key[t],
                             cap_idx[t], ref_key(key, dec ? 16 - t : t + 1), t);
                else n_pass++;
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [63:0] key;
        int          cyc;
        key = {$urandom, $urandom};
        key_valid_i = 1'b1; key_i = key; decrypt_i = 1'b0; round_key_ready_i = 1'b1;
        @(posedge clk); #1;
        key_valid_i = 1'b0;
        cyc = 0;
        while (round_idx_o !== 4'd5 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        n_checks++;
        if (round_idx_o !== 4'd5 || round_key_valid_o !== 1'b1)
            $display("FAIL reach_idx5 got i=%0d v=%b exp i=5 v=1", round_idx_o, round_key_valid_o);
        else n_pass++;
        rst = 1'b1;
        #1;
        n_checks++;
        if (round_key_valid_o !== 1'b0 || key_ready_o !== 1'b1 || round_idx_o !== 4'd0 || round_key_o !== 48'h0)
            $display("FAIL mid_reset got v=%b kr=%b i=%0d k=%h exp v=0 kr=1 i=0 k=0",
                     round_key_valid_o, key_ready_o, round_idx_o, round_key_o);
        else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (round_key_valid_o !== 1'b0) $display("FAIL no_resume got v=%b exp 0", round_key_valid_o); else n_pass++;
        key = {$urandom, $urandom};
        run_key(key, 1'b0, 0, -1, 1'b0);
        n_checks++;
        if (cap_key[0] !== ref_key(key, 1) || cap_idx[0] !== 4'd0)
            $display("FAIL after_reset_k1 got %h i=%0d exp %h i=0", cap_key[0], cap_idx[0], ref_key(key, 1));
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [63:0] key_a;
        logic [63:0] key_b;
        int          t;
        int          cyc;
        key_a = {$urandom, $urandom};
        key_b = {$urandom, $urandom};
        key_valid_i = 1'b1; key_i = key_a; decrypt_i = 1'b0; round_key_ready_i = 1'b1;
        @(posedge clk); #1;
        // Second key presented during the first schedule and held
        key_i = key_b; decrypt_i = 1'b1;
        t = 0; cyc = 0;
        while (t < 16 && cyc < 40) begin
            if (round_key_valid_o === 1'b1) begin
                n_checks++;
                if (round_key_o !== ref_key(key_a, t + 1))
                    $display("FAIL b2b_first t=%0d got %h exp %h", t, round_key_o, ref_key(key_a, t + 1));
                else n_pass++;
                t++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        n_checks++;
        if (cyc != 16) $display("FAIL b2b_first_cycles got %0d exp 16", cyc); else n_pass++;
        n_checks++;
        if (round_key_valid_o !== 1'b0 || key_ready_o !== 1'b1)
            $display("FAIL b2b_gap got v=%b kr=%b exp v=0 kr=1", round_key_valid_o, key_ready_o);
        else n_pass++;
        @(posedge clk); #1;
        key_valid_i = 1'b0;
        n_checks++;
        if (round_key_valid_o !== 1'b1 || round_idx_o !== 4'd0 || round_key_o !== ref_key(key_b, 16))
            $display("FAIL b2b_second_k16 got v=%b i=%0d k=%h exp v=1 i=0 k=%h",
                     round_key_valid_o, round_idx_o, round_key_o, ref_key(key_b, 16));
        else n_pass++;
        t = 0; cyc = 0;
        while (t < 16 && cyc < 40) begin
            if (round_key_valid_o === 1'b1) begin
                n_checks++;
                if (round_key_o !== ref_key(key_b, 16 - t) || round_idx_o !== 4'(t))
                    $display("FAIL b2b_second t=%0d got %h i=%0d exp %h i=%0d", t, round_key_o, round_idx_o,
                             ref_key(key_b, 16 - t), t);
                else n_pass++;
                t++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        n_checks++;
        if (key_ready_o !== 1'b1) $display("FAIL b2b_idle_end got %b exp 1", key_ready_o); else n_pass++;
        $display("run b2b keyA=%h keyB=%h dec=1 transfers=32", key_a, key_b);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_encrypt_vector();
        test_decrypt_vector();
        test_backpressure();
        test_parity();
        test_random();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
